// File: rtl/mul_result_adder.sv
// Final carry-propagate adder behind a carry-save multiplier: two-stage valid/ready
// pipeline returning the selected 64-bit half. Optional flush port: MUL_RESULT_ADDER_FLUSH_EN.
module mul_result_adder #(
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef MUL_RESULT_ADDER_FLUSH_EN
    input  logic             flush,
`endif
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sel,
    input  logic [TAG_W-1:0] in_tag,
    input  logic [63:0]      in_ls,
    input  logic [63:0]      in_lc,
    input  logic [63:0]      in_hs,
    input  logic [63:0]      in_hc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    logic             flush_int;

`ifdef MUL_RESULT_ADDER_FLUSH_EN
    assign flush_int = flush;
`else
    assign flush_int = 1'b0;
`endif

    logic             s1_valid;
    logic [63:0]      s1_lo;
    logic             s1_c;
    logic [63:0]      s1_hs;
    logic [63:0]      s1_hc;
    logic             s1_sel;
    logic [TAG_W-1:0] s1_tag;

    logic             s2_valid;
    logic [63:0]      s2_data;
    logic [TAG_W-1:0] s2_tag;

    logic             s2_load;
    logic             accept;
    logic [64:0]      lo_sum;
    logic [63:0]      hi_sum;

    // in_ready is derived from pipeline occupancy and out_ready only, never in_valid.
    assign s2_load  = s1_valid && (!s2_valid || out_ready);
    assign in_ready = !s1_valid || s2_load;
    assign accept   = in_valid && in_ready;

    assign lo_sum = {1'b0, in_ls} + {1'b0, in_lc};
    assign hi_sum = s1_hs + s1_hc + {63'd0, s1_c};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
        end else if (flush_int) begin
            s1_valid <= 1'b0;
        end else if (accept) begin
            s1_valid <= 1'b1;
        end else if (s2_load) begin
            s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_lo  <= '0;
            s1_c   <= 1'b0;
            s1_hs  <= '0;
            s1_hc  <= '0;
            s1_sel <= 1'b0;
            s1_tag <= '0;
        end else if (accept && !flush_int) begin
            s1_lo  <= lo_sum[63:0];
            s1_c   <= lo_sum[64];
            s1_hs  <= in_hs;
            s1_hc  <= in_hc;
            s1_sel <= in_sel;
            s1_tag <= in_tag;
        end
    end

    // The high-half carry-out is dropped: the product wraps mod 2^128.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
        end else if (flush_int) begin
            s2_valid <= 1'b0;
        end else if (s2_load) begin
            s2_valid <= 1'b1;
        end else if (out_ready) begin
            s2_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_data <= '0;
            s2_tag  <= '0;
        end else if (s2_load && !flush_int) begin
            s2_data <= s1_sel ? hi_sum : s1_lo;
            s2_tag  <= s1_tag;
        end
    end

    assign out_valid = s2_valid;
    assign out_data  = s2_data;
    assign out_tag   = s2_tag;
    assign busy      = s1_valid || s2_valid;

endmodule

// File: tb/tb_mul_result_adder.sv
// Self-checking bench for mul_result_adder: a 128-bit sum reference with an in-order
// expectation queue, checked every cycle, plus literal directed cases.
module tb_mul_result_adder;

    localparam int TAG_W = 5;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             flush_s = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic             in_sel = 1'b0;
    logic [TAG_W-1:0] in_tag = '0;
    logic [63:0]      in_ls = '0;
    logic [63:0]      in_lc = '0;
    logic [63:0]      in_hs = '0;
    logic [63:0]      in_hc = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [63:0]      out_data;
    logic [TAG_W-1:0] out_tag;
    logic             busy;

    int errors = 0;
    int checks = 0;
    int drains = 0;
    int cyc = 0;
    bit bp_en = 0;

    logic [63:0]      exp_q[$];
    logic [TAG_W-1:0] tag_q[$];

    mul_result_adder #(.TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef MUL_RESULT_ADDER_FLUSH_EN
        .flush     (flush_s),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sel    (in_sel),
        .in_tag    (in_tag),
        .in_ls     (in_ls),
        .in_lc     (in_lc),
        .in_hs     (in_hs),
        .in_hc     (in_hc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, req, $time);
        end
    endtask

    // The whole product is just the 128-bit sum of the two carry-save vectors.
    function automatic logic [63:0] ref_res(input logic sel, input logic [63:0] ls, lc, hs, hc);
        logic [127:0] s;
        s = {hs, ls} + {hc, lc};
        return sel ? s[127:64] : s[63:0];
    endfunction

    logic             hold_p = 1'b0;
    logic [63:0]      hold_d;
    logic [TAG_W-1:0] hold_t;

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            tag_q.delete();
            hold_p = 1'b0;
        end else begin
            chk("busy", busy, exp_q.size() != 0);
            chk("in_ready", in_ready, (exp_q.size() < 2) || out_ready);
            if (exp_q.size() == 0) chk("idle_out_valid", out_valid, 1'b0);
            if (hold_p) begin
                chk("stall_valid", out_valid, 1'b1);
                chk("stall_data", out_data, hold_d);
                chk("stall_tag", out_tag, hold_t);
            end
            if (out_valid && out_ready) begin
                drains++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", out_valid, 1'b0);
                end else begin
                    chk("result_data", out_data, exp_q.pop_front());
                    chk("result_tag", out_tag, tag_q.pop_front());
                end
            end
            hold_p = out_valid && !out_ready && !flush_s;
            hold_d = out_data;
            hold_t = out_tag;
            if (flush_s) begin
                exp_q.delete();
                tag_q.delete();
            end else if (in_valid && in_ready) begin
                exp_q.push_back(ref_res(in_sel, in_ls, in_lc, in_hs, in_hc));
                tag_q.push_back(in_tag);
            end
        end
    end

    task automatic set_in(input logic sel, input logic [63:0] ls, lc, hs, hc,
                          input logic [TAG_W-1:0] tag);
        in_sel = sel; in_ls = ls; in_lc = lc; in_hs = hs; in_hc = hc; in_tag = tag;
    endtask

    task automatic send(input logic sel, input logic [63:0] ls, lc, hs, hc,
                        input logic [TAG_W-1:0] tag);
        bit done = 0;
        set_in(sel, ls, lc, hs, hc, tag);
        in_valid = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            done = in_ready;
            @(posedge clk);
            #1;
            if (bp_en) out_ready = 1'($urandom_range(0, 1));
        end
        in_valid = 1'b0;
        if (!done) chk("send_timeout", 64'(done), 64'd1);
    endtask

    task automatic wait_idle();
        bit idle = 0;
        for (int i = 0; i < 100 && !idle; i++) begin
            @(negedge clk);
            idle = (exp_q.size() == 0) && !busy;
        end
        if (!idle) chk("idle_timeout", 64'(idle), 64'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic send_rand();
        send(1'($urandom_range(0, 1)), {$urandom, $urandom}, {$urandom, $urandom},
             {$urandom, $urandom}, {$urandom, $urandom}, TAG_W'($urandom));
    endtask

    initial begin
        int c0;
        int d0;
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_out_tag", out_tag, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Low half: all-ones + 1 wraps to zero with a carry into the high half.
        set_in(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 64'd0, 5'd3);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("lo_valid", out_valid, 1'b1);
        chk("lo_data", out_data, 64'd0);
        chk("lo_tag", out_tag, 64'd3);
        wait_idle();

        // High half: 5 + 7 + carry from the low half = 13.
        set_in(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd5, 64'd7, 5'd9);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("hi_valid", out_valid, 1'b1);
        chk("hi_data", out_data, 64'd13);
        chk("hi_tag", out_tag, 64'd9);
        wait_idle();

        // Stall: two held, third refused, output stable, then drained in order.
        out_ready = 1'b0;
        send(1'b0, 64'd10, 64'd20, 64'd0, 64'd0, 5'd1);
        send(1'b1, 64'd0, 64'd0, 64'd100, 64'd23, 5'd2);
        set_in(1'b0, 64'd40, 64'd2, 64'd0, 64'd0, 5'd4);
        in_valid = 1'b1;
        @(negedge clk);
        chk("stall_third_refused", in_ready, 1'b0);
        chk("stall_first_data", out_data, 64'd30);
        chk("stall_first_tag", out_tag, 64'd1);
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(1'b0, 64'd40, 64'd2, 64'd0, 64'd0, 5'd4);
        wait_idle();

        // Reset with two entries held.
        out_ready = 1'b0;
        send_rand();
        send_rand();
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", out_valid, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_in_ready", in_ready, 1'b1);
        chk("mid_rst_out_data", out_data, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_no_stale", out_valid, 1'b0);
        end
        @(posedge clk); #1;

        // Streaming at full rate.
        c0 = cyc;
        d0 = drains;
        for (int i = 0; i < 100; i++) send_rand();
        chk("stream_rate", 64'(cyc - c0), 64'd100);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("stream_results", 64'(drains - d0), 64'd100);
        wait_idle();

        // Random backpressure and gaps.
        bp_en = 1;
        for (int i = 0; i < 150; i++) begin
            send_rand();
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
                out_ready = 1'($urandom_range(0, 1));
            end
        end
        bp_en = 0;
        out_ready = 1'b1;
        wait_idle();

`ifdef MUL_RESULT_ADDER_FLUSH_EN
        out_ready = 1'b0;
        d0 = drains;
        send_rand();
        send_rand();
        set_in(1'b0, 64'd1, 64'd2, 64'd0, 64'd0, 5'd7);
        in_valid = 1'b1;
        flush_s = 1'b1;
        @(posedge clk); #1;
        flush_s = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("flush_out_valid", out_valid, 1'b0);
        chk("flush_busy", busy, 1'b0);
        out_ready = 1'b1;
        repeat (4) @(negedge clk);
        chk("flush_no_results", 64'(drains - d0), 64'd0);
        wait_idle();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
